// File: rtl/xor_unit_arbiter.sv
// Two-requester round-robin front end for a shared 32-bit bitwise logic unit.
// Each operation runs through IDLE -> EXEC -> DONE, and the result is held until it is consumed.
module xor_unit_arbiter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [1:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [1:0]       req1_op,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_out,
  output logic             res_id,
  output logic             res_zero,
  output logic             busy,
  output logic [CNT_W-1:0] ops_done
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t           state;
  logic             last_grant;
  logic             grant1;
  logic             accept;
  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] b_p0;
  logic [1:0]       op_p0;
  logic             id_p0;
  logic [WIDTH-1:0] result_p1;

  function automatic logic [WIDTH-1:0] bitop(input logic [WIDTH-1:0] a,
                                             input logic [WIDTH-1:0] b,
                                             input logic [1:0]       op);
    case (op)
      2'b00:   return a ^ b;
      2'b01:   return a & b;
      2'b10:   return a | b;
      default: return ~(a | b);
    endcase
  endfunction

  // A tie goes to the requester that was not granted last.
  always_comb begin
    grant1     = req1_valid && (!req0_valid || !last_grant);
    req0_ready = (state == IDLE) && !reset && req0_valid && !grant1;
    req1_ready = (state == IDLE) && !reset && grant1;
    accept     = req0_ready || req1_ready;
  end

  assign busy = (state != IDLE);

  // p0: operand capture on the accepting edge (data only, not reset)
  always_ff @(posedge clk) begin
    if (accept) begin
      a_p0  <= grant1 ? req1_a  : req0_a;
      b_p0  <= grant1 ? req1_b  : req0_b;
      op_p0 <= grant1 ? req1_op : req0_op;
      id_p0 <= grant1;
    end
  end

  // p1: bitwise evaluation, registered in EXEC
  assign result_p1 = bitop(a_p0, b_p0, op_p0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      res_valid  <= 1'b0;
      res_out    <= '0;
      res_id     <= 1'b0;
      res_zero   <= 1'b0;
      ops_done   <= '0;
      last_grant <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            last_grant <= grant1;
            state      <= EXEC;
          end
        end
        EXEC: begin
          res_out   <= result_p1;
          res_zero  <= (result_p1 == '0);
          res_id    <= id_p0;
          res_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            ops_done  <= ops_done + CNT_W'(1);
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_xor_unit_arbiter.sv
// Directed bench for xor_unit_arbiter: a table of single-requester operations,
// followed by round-robin, backpressure and reset-during-EXEC sequences.
module tb_xor_unit_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [1:0]  req0_op, req1_op;
  logic        res_valid, res_ready, res_id, res_zero, busy;
  logic [31:0] res_out;
  logic [15:0] ops_done;

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_done;
  logic        exp_last;

  typedef struct {
    logic        id;
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic [31:0] exp;
    logic        z;
  } vec_t;
  vec_t tbl[7];

  always #5 clk = ~clk;

  xor_unit_arbiter #(.WIDTH(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .res_valid(res_valid), .res_ready(res_ready), .res_out(res_out), .res_id(res_id),
    .res_zero(res_zero), .busy(busy), .ops_done(ops_done)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive_req(input logic id, input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    if (id) begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
    end else begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
    end
  endtask

  // One complete operation from a single requester, consumed immediately.
  task automatic run_txn(input vec_t v, input int idx);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    drive_req(v.id, v.a, v.b, v.op);
    #1;
    chk($sformatf("v%0d ready0", idx), req0_ready, !v.id);
    chk($sformatf("v%0d ready1", idx), req1_ready, v.id);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~req0_a; req1_b = ~req1_b; req0_op = ~req0_op; req1_op = ~req1_op;
    chk($sformatf("v%0d exec busy", idx), busy, 1'b1);
    chk($sformatf("v%0d exec res_valid", idx), res_valid, 1'b0);
    @(posedge clk);
    @(negedge clk);
    chk($sformatf("v%0d res_valid", idx), res_valid, 1'b1);
    chk($sformatf("v%0d res_out", idx), res_out, v.exp);
    chk($sformatf("v%0d res_id", idx), res_id, v.id);
    chk($sformatf("v%0d res_zero", idx), res_zero, v.z);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    exp_done = exp_done + 16'd1;
    exp_last = v.id;
    chk($sformatf("v%0d consumed", idx), res_valid, 1'b0);
    chk($sformatf("v%0d ops_done", idx), ops_done, exp_done);
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 2'b00, 32'h00000000, 1'b1};
    tbl[1] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 2'b00, 32'h0FF00FF0, 1'b0};
    tbl[2] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 2'b01, 32'hF000F000, 1'b0};
    tbl[3] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 2'b10, 32'hFFF0FFF0, 1'b0};
    tbl[4] = '{1'b1, 32'hF0F0F0F0, 32'hFF00FF00, 2'b11, 32'h000F000F, 1'b0};
    tbl[5] = '{1'b0, 32'h00000000, 32'hDEADBEEF, 2'b01, 32'h00000000, 1'b1};
    tbl[6] = '{1'b0, 32'hFFFFFFFF, 32'h00000000, 2'b11, 32'h00000000, 1'b1};

    reset = 1'b1; res_ready = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0; req1_a = '0; req1_b = '0; req1_op = '0;
    exp_done = '0; exp_last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst res_valid", res_valid, 1'b0);
    chk("rst busy", busy, 1'b0);
    chk("rst ops_done", ops_done, 16'd0);
    chk("rst res_out", res_out, 32'h0);
    chk("rst res_id", res_id, 1'b0);
    chk("rst res_zero", res_zero, 1'b0);
    chk("rst ready0", req0_ready, 1'b0);
    chk("rst ready1", req1_ready, 1'b0);

    for (int i = 0; i < 7; i++) run_txn(tbl[i], i);

    // Round robin with both requesters always valid and the consumer always ready.
    @(negedge clk);
    drive_req(1'b0, 32'h12345678, 32'h00000000, 2'b00);
    drive_req(1'b1, 32'h00000000, 32'h00000000, 2'b11);
    res_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      logic exp_g;
      int   w;
      exp_g = !exp_last;
      w = 0;
      #1;
      while (!(req0_ready || req1_ready) && w < 10) begin
        @(negedge clk); #1; w++;
      end
      chk($sformatf("rr%0d grant seen", k), (w < 10), 1'b1);
      chk($sformatf("rr%0d ready1", k), req1_ready, exp_g);
      chk($sformatf("rr%0d ready0", k), req0_ready, !exp_g);
      @(posedge clk);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("rr%0d res_valid", k), res_valid, 1'b1);
      chk($sformatf("rr%0d res_id", k), res_id, exp_g);
      chk($sformatf("rr%0d res_out", k), res_out, exp_g ? 32'hFFFFFFFF : 32'h12345678);
      exp_last = exp_g;
      exp_done = exp_done + 16'd1;
    end
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    chk("rr ops_done", ops_done, exp_done);

    // Backpressure: result held for 5 cycles while requester 1 waits.
    @(negedge clk);
    drive_req(1'b0, 32'hAAAAAAAA, 32'h55555555, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    drive_req(1'b1, 32'h0000FFFF, 32'h0000FFFF, 2'b00);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d res_valid", c), res_valid, 1'b1);
      chk($sformatf("bp%0d res_out", c), res_out, 32'hFFFFFFFF);
      chk($sformatf("bp%0d res_id", c), res_id, 1'b0);
      chk($sformatf("bp%0d readies", c), {req0_ready, req1_ready}, 2'b00);
      chk($sformatf("bp%0d busy", c), busy, 1'b1);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
    exp_done = exp_done + 16'd1;
    #1;
    chk("bp consumed", res_valid, 1'b0);
    chk("bp ops_done", ops_done, exp_done);
    chk("bp idle busy", busy, 1'b0);
    chk("bp next grant1", req1_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("bp2 res_id", res_id, 1'b1);
    chk("bp2 res_zero", res_zero, 1'b1);
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;

    // Reset during EXEC discards the operation and restores the initial tie-break.
    drive_req(1'b0, 32'h0F0F0F0F, 32'h00000000, 2'b10);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0;
    chk("mid exec busy", busy, 1'b1);
    reset = 1'b1;
    drive_req(1'b0, 32'h1, 32'h2, 2'b00);
    drive_req(1'b1, 32'h3, 32'h4, 2'b00);
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("midrst res_valid", res_valid, 1'b0);
    chk("midrst busy", busy, 1'b0);
    chk("midrst ops_done", ops_done, 16'd0);
    chk("midrst readies", {req0_ready, req1_ready}, 2'b00);
    reset = 1'b0;
    #1;
    chk("post rst ready0", req0_ready, 1'b1);
    chk("post rst ready1", req1_ready, 1'b0);
    @(posedge clk);
    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("post rst res_out", res_out, 32'h00000003);
    chk("post rst res_id", res_id, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule
